// File: rtl/ureg_pkg.sv
// Shared mode codes and per-bit control bundle for universal_register.
package ureg_pkg;

  localparam int unsigned UREG_MODE_W = 3;

  localparam logic [UREG_MODE_W-1:0] UREG_HOLD   = 3'd0;
  localparam logic [UREG_MODE_W-1:0] UREG_LOAD   = 3'd1;
  localparam logic [UREG_MODE_W-1:0] UREG_JK     = 3'd2;
  localparam logic [UREG_MODE_W-1:0] UREG_TOGGLE = 3'd3;
  localparam logic [UREG_MODE_W-1:0] UREG_SHL    = 3'd4;
  localparam logic [UREG_MODE_W-1:0] UREG_SHR    = 3'd5;
  localparam logic [UREG_MODE_W-1:0] UREG_INC    = 3'd6;
  localparam logic [UREG_MODE_W-1:0] UREG_DEC    = 3'd7;

  // One-hot operation selects shared by every bit cell; all low means hold.
  typedef struct packed {
    logic load;
    logic jk;
    logic tog;
    logic shift;
    logic count;
  } ureg_ctrl_t;

endpackage

// File: rtl/universal_register_jkt_cell.sv
// One storage bit of universal_register: D/JK/T behaviour plus shift and count inputs.
module jkt_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic jk,
  input  logic tog,
  input  logic shift,
  input  logic count,
  input  logic d,
  input  logic k,
  input  logic shift_in,
  input  logic count_in,
  output logic q
);

  logic q_nxt;

  // Selects are mutually exclusive; the priority order is only for synthesis.
  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = d;
    end else if (jk) begin
      case ({d, k})
        2'b01:   q_nxt = 1'b0;
        2'b10:   q_nxt = 1'b1;
        2'b11:   q_nxt = ~q;
        default: q_nxt = q;
      endcase
    end else if (tog) begin
      q_nxt = q ^ d;
    end else if (shift) begin
      q_nxt = shift_in;
    end else if (count) begin
      q_nxt = count_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_BIT;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/universal_register.sv
// Word-wide multi-mode register built from jkt_cell bits.
// Optional macro UREG_COUNT_EN enables INC/DEC modes and the wrap flag.
module universal_register
  import ureg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [UREG_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]       d,
  input  logic [WIDTH-1:0]       k,
  input  logic                   sin,
  output logic [WIDTH-1:0]       q,
  output logic                   sout,
  output logic                   wrap
);

  ureg_ctrl_t       ctrl;
  logic             shl_sel;
  logic [WIDTH-1:0] shift_vec;
  logic [WIDTH-1:0] cnt_nxt;
  logic             sout_nxt;

  // Mode decode; en low forces every select off so the cells hold.
  always_comb begin
    ctrl    = '0;
    shl_sel = 1'b0;
    if (en) begin
      case (mode)
        UREG_LOAD:   ctrl.load = 1'b1;
        UREG_JK:     ctrl.jk   = 1'b1;
        UREG_TOGGLE: ctrl.tog  = 1'b1;
        UREG_SHL: begin
          ctrl.shift = 1'b1;
          shl_sel    = 1'b1;
        end
        UREG_SHR:    ctrl.shift = 1'b1;
`ifdef UREG_COUNT_EN
        UREG_INC,
        UREG_DEC:    ctrl.count = 1'b1;
`endif
        default:     ctrl = '0;
      endcase
    end
  end

  // Serial neighbour selection; end bits take sin.
  genvar i;
  generate
    for (i = 0; i < int'(WIDTH); i++) begin : g_bit
      if (WIDTH == 1) begin : g_one
        assign shift_vec[i] = sin;
      end else if (i == 0) begin : g_lsb
        assign shift_vec[i] = shl_sel ? sin : q[i+1];
      end else if (i == int'(WIDTH) - 1) begin : g_msb
        assign shift_vec[i] = shl_sel ? q[i-1] : sin;
      end else begin : g_mid
        assign shift_vec[i] = shl_sel ? q[i-1] : q[i+1];
      end

      jkt_cell #(
        .RST_BIT(RESET_VALUE[i])
      ) u_cell (
        .clk      (clk),
        .rst      (rst),
        .load     (ctrl.load),
        .jk       (ctrl.jk),
        .tog      (ctrl.tog),
        .shift    (ctrl.shift),
        .count    (ctrl.count),
        .d        (d[i]),
        .k        (k[i]),
        .shift_in (shift_vec[i]),
        .count_in (cnt_nxt[i]),
        .q        (q[i])
      );
    end
  endgenerate

  assign sout_nxt = shl_sel ? q[WIDTH-1] : q[0];

  // sout only moves on shift edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sout <= 1'b0;
    else if (ctrl.shift) sout <= sout_nxt;
  end

`ifdef UREG_COUNT_EN
  logic is_dec;
  logic wrap_nxt;

  // Carry/borrow chain and wrap detection live here, not in the cells.
  always_comb begin
    is_dec   = (mode == UREG_DEC);
    cnt_nxt  = is_dec ? (q - WIDTH'(1)) : (q + WIDTH'(1));
    wrap_nxt = ctrl.count & (is_dec ? (q == '0) : (q == '1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= wrap_nxt;
  end
`else
  assign cnt_nxt = '0;
  assign wrap    = 1'b0;
`endif

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register (WIDTH=8, RESET_VALUE=8'hA5).
module tb_universal_register;

  localparam int unsigned W = 8;
`ifdef UREG_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_JK = 3'd2, M_TOG = 3'd3,
                         M_SHL = 3'd4, M_SHR = 3'd5, M_INC = 3'd6, M_DEC = 3'd7;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d, k;
  logic         sin;
  logic [W-1:0] q;
  logic         sout, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] k;
    logic         sin;
    logic [W-1:0] eq;
    logic         es;
    logic         ew;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         sout;
    logic         wrap;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  logic [W-1:0] m_q;
  logic         m_s, m_w;

  universal_register #(.WIDTH(W), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .k(k),
    .sin(sin), .q(q), .sout(sout), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic e, logic [2:0] m, logic [W-1:0] dd, logic [W-1:0] kk,
                              logic s, logic [W-1:0] eq, logic es, logic ew);
    vec_t v;
    v.en = e; v.mode = m; v.d = dd; v.k = kk; v.sin = s;
    v.eq = eq; v.es = es; v.ew = ew;
    return v;
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Independent behavioural reference for one enabled/disabled edge.
  task automatic model_step(logic e, logic [2:0] m, logic [W-1:0] dd, logic [W-1:0] kk, logic s);
    m_w = 1'b0;
    if (e) begin
      case (m)
        M_LOAD: m_q = dd;
        M_JK:   m_q = (dd & ~m_q) | (~kk & m_q);
        M_TOG:  m_q = m_q ^ dd;
        M_SHL:  begin m_s = m_q[W-1]; m_q = {m_q[W-2:0], s}; end
        M_SHR:  begin m_s = m_q[0];   m_q = {s, m_q[W-1:1]}; end
        M_INC:  if (CNT) begin m_w = (m_q == 8'hFF); m_q = m_q + 8'd1; end
        M_DEC:  if (CNT) begin m_w = (m_q == 8'h00); m_q = m_q - 8'd1; end
        default: ;
      endcase
    end
  endtask

  // Drive one edge, push expectation, pop and compare after the edge.
  task automatic step(string name, logic e, logic [2:0] m, logic [W-1:0] dd,
                      logic [W-1:0] kk, logic s, logic [W-1:0] eq, logic es, logic ew);
    exp_t x, y;
    en = e; mode = m; d = dd; k = kk; sin = s;
    x.q = eq; x.sout = es; x.wrap = ew;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    check({name, ".q"},    q,           y.q);
    check({name, ".sout"}, W'(sout),    W'(y.sout));
    check({name, ".wrap"}, W'(wrap),    W'(y.wrap));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = M_HOLD; d = '0; k = '0; sin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.q", q, 8'hA5);
    check("reset.sout", W'(sout), W'(1'b0));
    check("reset.wrap", W'(wrap), W'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(1, M_LOAD, 8'hF0, 8'h00, 0, 8'hF0, 0, 0));
    tbl.push_back(mk(1, M_JK,   8'hCA, 8'hA6, 0, 8'h5A, 0, 0));
    tbl.push_back(mk(1, M_TOG,  8'hFF, 8'h00, 0, 8'hA5, 0, 0));
    tbl.push_back(mk(1, M_LOAD, 8'h81, 8'h00, 0, 8'h81, 0, 0));
    tbl.push_back(mk(1, M_SHL,  8'h00, 8'h00, 0, 8'h02, 1, 0));
    tbl.push_back(mk(1, M_TOG,  8'h00, 8'h00, 0, 8'h02, 1, 0));
    tbl.push_back(mk(1, M_SHR,  8'h00, 8'h00, 1, 8'h81, 0, 0));
    tbl.push_back(mk(1, M_LOAD, 8'hFE, 8'h00, 0, 8'hFE, 0, 0));
    tbl.push_back(mk(1, M_INC,  8'h00, 8'h00, 0, CNT ? 8'hFF : 8'hFE, 0, 0));
    tbl.push_back(mk(1, M_INC,  8'h00, 8'h00, 0, CNT ? 8'h00 : 8'hFE, 0, CNT));
    tbl.push_back(mk(1, M_HOLD, 8'h33, 8'h44, 1, CNT ? 8'h00 : 8'hFE, 0, 0));
    tbl.push_back(mk(1, M_DEC,  8'h00, 8'h00, 0, CNT ? 8'hFF : 8'hFE, 0, CNT));
    tbl.push_back(mk(1, M_INC,  8'h00, 8'h00, 0, CNT ? 8'h00 : 8'hFE, 0, CNT));
    tbl.push_back(mk(1, M_LOAD, 8'h05, 8'h00, 0, 8'h05, 0, 0));
    tbl.push_back(mk(1, M_DEC,  8'h00, 8'h00, 0, CNT ? 8'h04 : 8'h05, 0, 0));
    tbl.push_back(mk(1, M_LOAD, 8'h55, 8'h00, 0, 8'h55, 0, 0));
    tbl.push_back(mk(0, M_LOAD, 8'h00, 8'h00, 0, 8'h55, 0, 0));
    tbl.push_back(mk(0, M_LOAD, 8'h00, 8'hFF, 1, 8'h55, 0, 0));
    tbl.push_back(mk(0, M_LOAD, 8'h00, 8'h00, 1, 8'h55, 0, 0));
    tbl.push_back(mk(1, M_LOAD, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, M_LOAD, 8'hFF, 8'h00, 0, 8'hFF, 0, 0));
    tbl.push_back(mk(1, M_INC,  8'h00, 8'h00, 0, CNT ? 8'h00 : 8'hFF, 0, CNT));
    tbl.push_back(mk(0, M_INC,  8'h00, 8'h00, 0, CNT ? 8'h00 : 8'hFF, 0, 0));
    tbl.push_back(mk(1, M_SHL,  8'h00, 8'h00, 1, CNT ? 8'h01 : 8'hFF, CNT ? 1'b0 : 1'b1, 0));

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].k,
           tbl[i].sin, tbl[i].eq, tbl[i].es, tbl[i].ew);
    end

    // Random traffic against the reference model.
    m_q = tbl[tbl.size()-1].eq;
    m_s = tbl[tbl.size()-1].es;
    m_w = tbl[tbl.size()-1].ew;
    for (int n = 0; n < 300; n++) begin
      logic         re, rs;
      logic [2:0]   rm;
      logic [W-1:0] rd, rk;
      re = ($urandom_range(0, 7) != 0);
      rm = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      rk = 8'($urandom);
      rs = 1'($urandom);
      if (n % 40 == 0) begin re = 1'b1; rm = M_LOAD; rd = (n % 80 == 0) ? 8'hFF : 8'h00; end
      model_step(re, rm, rd, rk, rs);
      step($sformatf("rnd%0d", n), re, rm, rd, rk, rs, m_q, m_s, m_w);
    end

    // Asynchronous reset mid-cycle, then edges ignored while held.
    step("pre_rst", 1, M_LOAD, 8'h3C, 8'h00, 0, 8'h3C, m_s, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.q", q, 8'hA5);
    check("async_rst.sout", W'(sout), W'(1'b0));
    check("async_rst.wrap", W'(wrap), W'(1'b0));
    en = 1'b1; mode = M_LOAD; d = 8'hFF;
    @(posedge clk);
    #1;
    check("rst_held.q", q, 8'hA5);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1, M_LOAD, 8'h3C, 8'h00, 0, 8'h3C, 0, 0);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
